// File: rtl/exe_muldiv_if.sv
// Request/response bundle for the exe_muldiv iterative multiply/divide unit.
// Ports:
//   in_valid/in_ready  request handshake (op, word, op1, op2 qualify it)
//   flush              abandon any in-flight operation
//   out_valid/out_ready result handshake (result qualifies it)
//   busy               unit is in CALC or DONE
interface exe_muldiv_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            word;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, word, op1, op2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, word, op1, op2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative RISC-V M-extension execute unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with fast paths for divide-by-zero,
// signed overflow and word-mode MULH*.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    exe_muldiv_if.slave request/response bundle
// Timing: the accept edge captures prepared operands; the following edge
// either completes a fast-path result (DONE) or enters CALC for N cycles.
module exe_muldiv #(
    parameter int XLEN = 64,
    parameter int W_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    exe_muldiv_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    localparam int         CW   = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    logic [1:0]        state;
    logic              pend;      // operands captured, decision made next edge
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              wd_q;
    logic              sgn1_q;
    logic              sgn2_q;
    logic [XLEN-1:0]   mag1_q;
    logic [XLEN-1:0]   mag2_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] acc;       // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return XLEN'($signed(v[31:0]));
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                   input logic neg, input logic wd);
        logic [XLEN-1:0] t;
        t = neg ? -v : v;
        return wd ? sext32(t) : t;
    endfunction

    // In word mode the product ends up left-shifted by XLEN-32 inside acc,
    // so the low word sits at acc[XLEN-1 -: 32].
    function automatic logic [XLEN-1:0] select_result(input logic [2:0] o, input logic wd,
                                                      input logic n1, input logic n2,
                                                      input logic [2*XLEN-1:0] a);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   r;
        p = (n1 ^ n2) ? -a : a;
        case (o)
            3'b000:                 r = wd ? sext32(XLEN'(p[XLEN-1 -: 32])) : p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: r = p[2*XLEN-1:XLEN];
            3'b100, 3'b101:         r = apply_sign(a[XLEN-1:0], n1 ^ n2, wd);
            default:                r = apply_sign(a[2*XLEN-1:XLEN], n1, wd);
        endcase
        return r;
    endfunction

    // Operand preparation from the live request
    logic            wd_in, s1_in, s2_in, n1_in, n2_in;
    logic [XLEN-1:0] e1_in, e2_in, m1_in, m2_in;

    always_comb begin
        wd_in = bus.word && (W_EN != 0) && (XLEN == 64);
        s1_in = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
        s2_in = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        e1_in = bus.op1;
        e2_in = bus.op2;
        if (wd_in) begin
            e1_in = s1_in ? sext32(bus.op1) : XLEN'(bus.op1[31:0]);
            e2_in = s2_in ? sext32(bus.op2) : XLEN'(bus.op2[31:0]);
        end
        n1_in = s1_in && e1_in[XLEN-1];
        n2_in = s2_in && e2_in[XLEN-1];
        m1_in = n1_in ? -e1_in : e1_in;
        m2_in = n2_in ? -e2_in : e2_in;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] acc_nx;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag1_q} : '0);
        rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = rem_sh - {1'b0, mag2_q};
        if (!op_q[2])
            acc_nx = {mul_sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    // Fast-path detection on the captured operands
    logic            div_zero, ovf, wd_mulh, fast;
    logic [XLEN-1:0] fast_val;

    always_comb begin
        div_zero = op_q[2] && (mag2_q == '0);
        ovf      = op_q[2] && !op_q[0] && sgn1_q && sgn2_q && (mag2_q == ONE) &&
                   (mag1_q == (wd_q ? (ONE << 31) : (ONE << (XLEN-1))));
        wd_mulh  = wd_q && !op_q[2] && (op_q != 3'b000);
        fast     = div_zero || ovf || wd_mulh;
        fast_val = '0;
        if (div_zero)
            fast_val = op_q[1] ? apply_sign(mag1_q, sgn1_q, wd_q) : '1;
        else if (ovf)
            fast_val = op_q[1] ? '0 : apply_sign(mag1_q, sgn1_q, wd_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            wd_q     <= 1'b0;
            sgn1_q   <= 1'b0;
            sgn2_q   <= 1'b0;
            mag1_q   <= '0;
            mag2_q   <= '0;
            result_q <= '0;
            acc      <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            pend  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        if (fast) begin
                            result_q <= fast_val;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                            cnt   <= wd_q ? CW'(31) : CW'(XLEN-1);
                        end
                    end else if (bus.in_valid) begin
                        pend   <= 1'b1;
                        op_q   <= bus.op;
                        wd_q   <= wd_in;
                        sgn1_q <= n1_in;
                        sgn2_q <= n2_in;
                        mag1_q <= m1_in;
                        mag2_q <= m2_in;
                        // dividend is left-aligned so its top bit is always acc[XLEN-1]
                        acc    <= !bus.op[2] ? {{XLEN{1'b0}}, m2_in}
                                             : {{XLEN{1'b0}}, (wd_in ? (m1_in << (XLEN-32)) : m1_in)};
                    end
                end
                CALC: begin
                    acc <= acc_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state    <= DONE;
                        result_q <= select_result(op_q, wd_q, sgn1_q, sgn2_q, acc_nx);
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !pend;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = (state == DONE) ? result_q : '0;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv (XLEN=64, W_EN=1): vector table with
// hand-computed results, a randomized pass against a behavioural model, and
// hand-written sequences for DONE back-pressure, flush and mid-op reset.
module tb_exe_muldiv;
    logic clk;
    logic rst_n;

    exe_muldiv_if #(.XLEN(64)) bus ();

    exe_muldiv #(.XLEN(64), .W_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    vec_t vt[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb, ps;
        logic [127:0]        pu;
        logic signed [63:0]  sa, sbv;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         r32;
        logic [63:0]         r;
        sa = a; sbv = b; sa32 = a[31:0]; sb32 = b[31:0];
        r = '0; r32 = '0;
        if (w) begin
            case (o)
                3'd0: r32 = a[31:0] * b[31:0];
                3'd4: begin
                    if (b[31:0] == 32'd0) r32 = '1;
                    else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
                    else r32 = sa32 / sb32;
                end
                3'd5: begin
                    if (b[31:0] == 32'd0) r32 = '1;
                    else r32 = a[31:0] / b[31:0];
                end
                3'd6: begin
                    if (b[31:0] == 32'd0) r32 = a[31:0];
                    else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = '0;
                    else r32 = sa32 % sb32;
                end
                3'd7: begin
                    if (b[31:0] == 32'd0) r32 = a[31:0];
                    else r32 = a[31:0] % b[31:0];
                end
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (o)
                3'd0: r = a * b;
                3'd1: begin pa = sa; pb = sbv; ps = pa * pb; r = ps[127:64]; end
                3'd2: begin pa = sa; pb = {64'd0, b}; ps = pa * pb; r = ps[127:64]; end
                3'd3: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
                3'd4: begin
                    if (b == 64'd0) r = '1;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                    else r = sa / sbv;
                end
                3'd5: begin
                    if (b == 64'd0) r = '1;
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 64'd0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                    else r = sa % sbv;
                end
                default: begin
                    if (b == 64'd0) r = a;
                    else r = a % b;
                end
            endcase
        end
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        if (w && (o == 3'd1 || o == 3'd2 || o == 3'd3)) return 1;
        if (o[2]) begin
            if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
            if (!o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
        end
        return w ? 33 : 65;
    endfunction

    task automatic drive_req(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.word     = w;
        bus.op1      = a;
        bus.op2      = b;
    endtask

    // Issue one request, wait for its result, compare value and latency, consume it.
    task automatic do_op(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        int   lat;
        check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        drive_req(v.op, v.w, v.a, v.b);
        e.res = v.res;
        e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sb.pop_front();
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no out_valid within %0d cycles", name, lat);
        end else begin
            check({name, " result"}, bus.result, got.res);
            check({name, " latency"}, 64'(lat), 64'(got.lat));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vt[0]  = '{op:3'd0, w:1'b0, a:64'd7, b:64'hFFFF_FFFF_FFFF_FFFD, res:64'hFFFF_FFFF_FFFF_FFEB, lat:65};
        vt[1]  = '{op:3'd3, w:1'b0, a:'1, b:'1, res:64'hFFFF_FFFF_FFFF_FFFE, lat:65};
        vt[2]  = '{op:3'd5, w:1'b0, a:64'd5, b:64'd0, res:'1, lat:1};
        vt[3]  = '{op:3'd7, w:1'b0, a:64'd5, b:64'd0, res:64'd5, lat:1};
        vt[4]  = '{op:3'd4, w:1'b0, a:64'h8000_0000_0000_0000, b:'1, res:64'h8000_0000_0000_0000, lat:1};
        vt[5]  = '{op:3'd6, w:1'b0, a:64'h8000_0000_0000_0000, b:'1, res:64'd0, lat:1};
        vt[6]  = '{op:3'd4, w:1'b1, a:64'h1234_5678_FFFF_FFF9, b:64'd2, res:64'hFFFF_FFFF_FFFF_FFFD, lat:33};
        vt[7]  = '{op:3'd6, w:1'b1, a:64'h1234_5678_FFFF_FFF9, b:64'd2, res:'1, lat:33};
        vt[8]  = '{op:3'd1, w:1'b0, a:64'h8000_0000_0000_0000, b:64'd2, res:'1, lat:65};
        vt[9]  = '{op:3'd2, w:1'b0, a:64'd2, b:'1, res:64'd1, lat:65};
        vt[10] = '{op:3'd4, w:1'b0, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, res:64'hFFFF_FFFF_FFFF_FFFD, lat:65};
        vt[11] = '{op:3'd6, w:1'b0, a:64'd7, b:64'hFFFF_FFFF_FFFF_FFFE, res:64'd1, lat:65};
        vt[12] = '{op:3'd5, w:1'b0, a:64'd100, b:64'd7, res:64'd14, lat:65};
        vt[13] = '{op:3'd0, w:1'b1, a:64'h0000_0001_0000_0003, b:64'h8000_0000, res:64'hFFFF_FFFF_8000_0000, lat:33};
        vt[14] = '{op:3'd1, w:1'b1, a:64'd12345, b:64'd678, res:64'd0, lat:1};
        vt[15] = '{op:3'd5, w:1'b1, a:64'hFFFF_FFFF, b:64'hABCD_0000_0000_0000, res:'1, lat:1};
        vt[16] = '{op:3'd7, w:1'b1, a:64'h8000_0000, b:64'd0, res:64'hFFFF_FFFF_8000_0000, lat:1};
        vt[17] = '{op:3'd4, w:1'b1, a:64'h8000_0000, b:64'hFFFF_FFFF, res:64'hFFFF_FFFF_8000_0000, lat:1};
        vt[18] = '{op:3'd0, w:1'b0, a:64'd3, b:64'd4, res:64'd12, lat:65};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.word      = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        #2;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", bus.result, 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);

        // release between edges; first vector is accepted on the very next edge
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            do_op(vt[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v.op = 3'($urandom_range(0, 7));
            v.w  = 1'($urandom_range(0, 1));
            v.a  = {$urandom, $urandom};
            v.b  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: v.b = '0;
                1: v.b = 64'($urandom_range(1, 9));
                2: v.a = -64'($urandom_range(1, 100));
                default: ;
            endcase
            v.res = model(v.op, v.w, v.a, v.b);
            v.lat = model_lat(v.op, v.w, v.a, v.b);
            do_op(v, $sformatf("rnd%0d", i));
        end

        // DONE back-pressure: result held while out_ready is low
        begin
            int lat;
            drive_req(3'd5, 1'b0, 64'd1000, 64'd9);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat = 0;
            while (!bus.out_valid && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            check("hold first valid", 64'(bus.out_valid), 64'd1);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check($sformatf("hold%0d out_valid", k), 64'(bus.out_valid), 64'd1);
                check($sformatf("hold%0d result", k), bus.result, 64'd111);
                check($sformatf("hold%0d in_ready", k), 64'(bus.in_ready), 64'd0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check("release out_valid", 64'(bus.out_valid), 64'd0);
            check("release result", bus.result, 64'd0);
            check("release in_ready", 64'(bus.in_ready), 64'd1);
            check("release busy", 64'(bus.busy), 64'd0);
        end

        // Flush at CALC cycle 10
        drive_req(3'd0, 1'b0, 64'd5, 64'd6);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        check("calc busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        check("flush in_ready", 64'(bus.in_ready), 64'd1);

        // Request offered together with flush must be ignored
        drive_req(3'd5, 1'b0, 64'd5, 64'd0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush-accept in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        check("flush-accept out_valid", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset during CALC
        drive_req(3'd0, 1'b0, 64'd9, 64'd9);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-reset busy", 64'(bus.busy), 64'd0);
        check("mid-reset in_ready", 64'(bus.in_ready), 64'd1);
        check("mid-reset result", bus.result, 64'd0);
        #7;
        rst_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 80; k++) begin
                @(posedge clk); #1;
                if (bus.out_valid) pulses++;
            end
            check("post-reset out_valid pulses", 64'(pulses), 64'd0);
        end

        do_op(vt[18], "after-reset mul");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
